// File: rtl/score_bcd_converter_pkg.sv
// Shared constants, state encoding and helpers for the score BCD converter.
package score_bcd_converter_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   // 10**n at 64 bits so the range limit never truncates for any legal DIGITS.
   function automatic logic [63:0] pow10(input int unsigned n);
      logic [63:0] r;
      r = 64'd1;
      for (int unsigned k = 0; k < n; k++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/score_bcd_converter_bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
module bcd_add3
   import score_bcd_converter_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] digit_adj_c
);

   assign digit_adj_c = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential double-dabble converter: binary score in, packed BCD digits plus
// leading-zero blank mask out, one input bit per cycle.
module score_bcd_converter
   import score_bcd_converter_pkg::*;
#(
   parameter int unsigned BIN_WIDTH = 17,
   parameter int unsigned DIGITS    = 5,
   parameter bit          SATURATE  = 1'b1
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BIN_WIDTH-1:0]          bin_in,
   output logic                          out_valid,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]             blank_out,
   output logic                          overflow
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
   localparam logic [DIGITS-1:0] RST_BLANK = ~DIGITS'(1);
   localparam logic [BCD_W-1:0]  SAT_VAL   = {DIGITS{4'h9}};

   state_t               state;
   logic [BIN_WIDTH-1:0] shreg;
   logic [BCD_W-1:0]     scratch;
   logic [BCD_W-1:0]     corr;
   logic [BCD_W-1:0]     scratch_nxt;
   logic [BCD_W-1:0]     bcd_nxt;
   logic [DIGITS-1:0]    blank_nxt;
   logic                 upper_zero;
   logic [CNT_W-1:0]     cnt;
   logic                 ovf_pend;
   logic                 accept;

   assign accept = in_valid & in_ready;

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit       (scratch[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
         .digit_adj_c (corr[BCD_DIGIT_W*g +: BCD_DIGIT_W])
      );
   end

   // Carry out of the top digit is dropped, which gives mod 10**DIGITS wrap.
   assign scratch_nxt = {corr[BCD_W-2:0], shreg[BIN_WIDTH-1]};
   assign bcd_nxt     = (SATURATE && ovf_pend) ? SAT_VAL : scratch_nxt;

   // Digit i is blanked when it and every more-significant digit are zero.
   always_comb begin
      blank_nxt  = '0;
      upper_zero = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
         upper_zero   = upper_zero & (bcd_nxt[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
         blank_nxt[i] = upper_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         bcd_out   <= '0;
         blank_out <= RST_BLANK;
         overflow  <= 1'b0;
         shreg     <= '0;
         scratch   <= '0;
         cnt       <= '0;
         ovf_pend  <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg    <= bin_in;
                  scratch  <= '0;
                  cnt      <= CNT_W'(BIN_WIDTH);
                  ovf_pend <= 64'(bin_in) > MAX_VAL;
                  in_ready <= 1'b0;
                  state    <= CONV;
               end
            end
            CONV: begin
               scratch <= scratch_nxt;
               shreg   <= shreg << 1;
               cnt     <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bcd_out   <= bcd_nxt;
                  blank_out <= blank_nxt;
                  overflow  <= ovf_pend;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: saturating and wrapping instances in lockstep.
module tb_score_bcd_converter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        in_valid;
   logic [16:0] bin_in;

   logic        in_ready,  out_valid,  overflow;
   logic [19:0] bcd_out;
   logic [4:0]  blank_out;
   logic        w_in_ready, w_out_valid, w_overflow;
   logic [19:0] w_bcd_out;
   logic [4:0]  w_blank_out;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   score_bcd_converter #(.BIN_WIDTH(17), .DIGITS(5), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .bin_in(bin_in), .out_valid(out_valid), .bcd_out(bcd_out),
      .blank_out(blank_out), .overflow(overflow)
   );

   score_bcd_converter #(.BIN_WIDTH(17), .DIGITS(5), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(w_in_ready),
      .bin_in(bin_in), .out_valid(w_out_valid), .bcd_out(w_bcd_out),
      .blank_out(w_blank_out), .overflow(w_overflow)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One accept then wait for the result; lat counts edges after the accept edge.
   task automatic run_conv(input logic [16:0] v, output int lat);
      in_valid = 1'b1;
      bin_in   = v;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   function automatic logic [19:0] bcd_model(input int v);
      logic [19:0] m;
      int r;
      r = v % 100000;
      for (int i = 0; i < 5; i++) begin
         m[4*i +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return m;
   endfunction

   function automatic logic [4:0] blank_model(input int v);
      logic [4:0] b;
      int lim;
      b   = 5'b0;
      lim = 10;
      for (int i = 1; i < 5; i++) begin
         b[i] = (v % 100000) < lim;
         lim  = lim * 10;
      end
      return b;
   endfunction

   task automatic test_reset();
      resetn = 1'b0; in_valid = 1'b0; bin_in = '0;
      step(); step();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (bcd_out !== 20'h00000) begin n_fail++; $display("FAIL reset_bcd got=%h exp=00000", bcd_out); end
      n_cmp++; if (blank_out !== 5'b11110) begin n_fail++; $display("FAIL reset_blank got=%b exp=11110", blank_out); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      resetn = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int lat;
      run_conv(17'd12345, lat);
      n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL basic_latency got=%0d exp=17", lat); end
      n_cmp++; if (bcd_out !== 20'h12345) begin n_fail++; $display("FAIL basic_bcd got=%h exp=12345", bcd_out); end
      n_cmp++; if (blank_out !== 5'b00000) begin n_fail++; $display("FAIL basic_blank got=%b exp=00000", blank_out); end
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width got=%b exp=0", out_valid); end
      n_cmp++; if (bcd_out !== 20'h12345) begin n_fail++; $display("FAIL basic_hold got=%h exp=12345", bcd_out); end
   endtask

   task automatic test_small();
      int lat;
      run_conv(17'd0, lat);
      n_cmp++; if (bcd_out !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd got=%h exp=00000", bcd_out); end
      n_cmp++; if (blank_out !== 5'b11110) begin n_fail++; $display("FAIL zero_blank got=%b exp=11110", blank_out); end
      run_conv(17'd42, lat);
      n_cmp++; if (bcd_out !== 20'h00042) begin n_fail++; $display("FAIL small_bcd got=%h exp=00042", bcd_out); end
      n_cmp++; if (blank_out !== 5'b11100) begin n_fail++; $display("FAIL small_blank got=%b exp=11100", blank_out); end
      step();
   endtask

   task automatic test_overflow();
      int lat;
      run_conv(17'd123456, lat);
      n_cmp++; if (bcd_out !== 20'h99999) begin n_fail++; $display("FAIL sat_bcd got=%h exp=99999", bcd_out); end
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_overflow got=%b exp=1", overflow); end
      n_cmp++; if (w_bcd_out !== 20'h23456) begin n_fail++; $display("FAIL wrap_bcd got=%h exp=23456", w_bcd_out); end
      n_cmp++; if (w_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_overflow got=%b exp=1", w_overflow); end
      n_cmp++; if (w_blank_out !== 5'b00000) begin n_fail++; $display("FAIL wrap_blank got=%b exp=00000", w_blank_out); end
      run_conv(17'd100000, lat);
      n_cmp++; if (bcd_out !== 20'h99999) begin n_fail++; $display("FAIL sat_edge_bcd got=%h exp=99999", bcd_out); end
      n_cmp++; if (w_bcd_out !== 20'h00000 || w_blank_out !== 5'b11110) begin
         n_fail++; $display("FAIL wrap_edge got=%h/%b exp=00000/11110", w_bcd_out, w_blank_out);
      end
      run_conv(17'd99999, lat);
      n_cmp++; if (bcd_out !== 20'h99999 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL max_in_range got=%h/%b exp=99999/0", bcd_out, overflow);
      end
      step();
   endtask

   task automatic test_ignored();
      int pulses, first;
      pulses = 0; first = 0;
      in_valid = 1'b1; bin_in = 17'd31337;
      step();
      for (int c = 1; c <= 40; c++) begin
         in_valid = (c == 3 || c == 9);
         bin_in   = (c == 3 || c == 9) ? 17'd55555 : 17'd31337;
         if (c == 4) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL conv_in_ready got=%b exp=0", in_ready); end
         end
         step();
         if (out_valid) begin
            pulses++;
            if (first == 0) first = c;
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (pulses !== 1) begin n_fail++; $display("FAIL ignored_pulses got=%0d exp=1", pulses); end
      n_cmp++; if (first !== 17) begin n_fail++; $display("FAIL ignored_latency got=%0d exp=17", first); end
      n_cmp++; if (bcd_out !== 20'h31337) begin n_fail++; $display("FAIL ignored_bcd got=%h exp=31337", bcd_out); end
   endtask

   task automatic test_back_to_back();
      int vals[$];
      int n;
      for (int k = 0; k <= 100; k++) vals.push_back(k * 997);
      vals.push_back(99999);
      vals.push_back(1);
      in_valid = 1'b1;
      bin_in   = 17'(vals[0]);
      for (int k = 0; k < vals.size(); k++) begin
         n = 0;
         do begin
            step();
            n++;
         end while (!out_valid && n < 40);
         n_cmp++; if (n !== 18) begin n_fail++; $display("FAIL b2b_interval v=%0d got=%0d exp=18", vals[k], n); end
         n_cmp++; if (bcd_out !== bcd_model(vals[k]) || blank_out !== blank_model(vals[k]) || overflow !== 1'b0) begin
            n_fail++; $display("FAIL b2b_sat v=%0d got=%h/%b/%b exp=%h/%b/0", vals[k], bcd_out, blank_out, overflow, bcd_model(vals[k]), blank_model(vals[k]));
         end
         n_cmp++; if (w_bcd_out !== bcd_model(vals[k])) begin
            n_fail++; $display("FAIL b2b_wrap v=%0d got=%h exp=%h", vals[k], w_bcd_out, bcd_model(vals[k]));
         end
         if (k + 1 < vals.size()) bin_in = 17'(vals[k+1]);
         else in_valid = 1'b0;
      end
      step();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_drain got=%b/%b exp=0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat, pulses;
      run_conv(17'd123456, lat);
      step();
      in_valid = 1'b1; bin_in = 17'd99999;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      resetn = 1'b0;
      step(); step();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_reset_hs got=%b/%b exp=0/1", out_valid, in_ready);
      end
      n_cmp++; if (bcd_out !== 20'h00000 || blank_out !== 5'b11110 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_out got=%h/%b/%b exp=00000/11110/0", bcd_out, blank_out, overflow);
      end
      resetn = 1'b1;
      pulses = 0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (out_valid) pulses++;
      end
      n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_reset_pulse got=%0d exp=0", pulses); end
      run_conv(17'd7, lat);
      n_cmp++; if (lat !== 17) begin n_fail++; $display("FAIL post_reset_latency got=%0d exp=17", lat); end
      n_cmp++; if (bcd_out !== 20'h00007 || blank_out !== 5'b11110 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_out got=%h/%b/%b exp=00007/11110/0", bcd_out, blank_out, overflow);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_small();
      test_overflow();
      test_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
